// File: rtl/awp_strob_seq.sv
// awp_strob_seq: strobe sequencer for the AWP control path.
// Converts a job-start pulse into a repeating strob1 / strob1b / strob2 /
// strob2b / got cycle. It selects the strob1 length from the delay-path lines,
// runs the memory-read handshake toward the CPU interface and supports
// single-step operation. All outputs are registered and are decoded from the
// state the FSM is about to enter.
module awp_strob_seq #(
    parameter int unsigned LEN_S2 = 2
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic start,
    input  logic halt,
    input  logic dp2,
    input  logic dp5,
    input  logic dp6,
    input  logic dp8,
    input  logic f1,
    input  logic zw,
    input  logic oken,
    input  logic di,
    input  logic mode,
    input  logic step,
    output logic strob1,
    output logic strob1b,
    output logic strob2,
    output logic strob2b,
    output logic ldstate,
    output logic got,
    output logic sr_fp,
    output logic busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S1,
        ST_S1B,
        ST_MREQ,
        ST_MWAIT,
        ST_S2,
        ST_S2B,
        ST_GOT,
        ST_STEPW
    } state_t;

    // The phase counter holds "cycles remaining minus one", so it is loaded
    // with length-1 on entry and the phase ends when it reads zero.
    localparam logic [3:0] S2_LAST = 4'(LEN_S2 - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_halt_seen;
    logic       r_step_q;
    logic       r_strob1;
    logic       r_strob1b;
    logic       r_strob2;
    logic       r_strob2b;
    logic       r_got;
    logic       r_sr_fp;
    logic       r_busy;

    state_t     w_next;
    logic [3:0] w_s1_last;
    logic       w_step_rise;
    logic       w_halt_any;
    logic       w_s1_entry;
    logic       w_s2_entry;

    assign w_step_rise = step & ~r_step_q;
    assign w_halt_any  = halt | r_halt_seen;
    assign w_s1_entry  = (w_next == ST_S1) && (r_state != ST_S1);
    assign w_s2_entry  = (w_next == ST_S2) && (r_state != ST_S2);

    // Delay-path priority decode: dp8 > dp6 > dp5 > dp2, default 2 cycles.
    always_comb begin
        if (dp8)      w_s1_last = 4'd7;
        else if (dp6) w_s1_last = 4'd5;
        else if (dp5) w_s1_last = 4'd4;
        else          w_s1_last = 4'd1;
    end

    // Next-state decision for the phase loop, handshake and step wait.
    always_comb begin
        // NOTE: assigning a default before the case gives every path a value, so no latch is inferred.
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_S1;
            ST_S1:    if (r_cnt == 4'd0) w_next = ST_S1B;
            ST_S1B:   w_next = f1 ? ST_MREQ : ST_S2;
            ST_MREQ: begin
                if (di)      w_next = ST_GOT;
                else if (zw) w_next = ST_MWAIT;
            end
            ST_MWAIT: begin
                if (di)        w_next = ST_GOT;
                else if (oken) w_next = ST_S2;
            end
            ST_S2:    if (r_cnt == 4'd0) w_next = ST_S2B;
            ST_S2B:   w_next = ST_GOT;
            ST_GOT: begin
                if (w_halt_any) w_next = ST_IDLE;
                else if (mode)  w_next = ST_STEPW;
                else            w_next = ST_S1;
            end
            ST_STEPW: begin
                if (halt)             w_next = ST_IDLE;
                else if (w_step_rise) w_next = ST_S1;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, phase counter, sticky halt, step edge register and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_halt_seen <= 1'b0;
            r_step_q    <= 1'b0;
            r_strob1    <= 1'b0;
            r_strob1b   <= 1'b0;
            r_strob2    <= 1'b0;
            r_strob2b   <= 1'b0;
            r_got       <= 1'b0;
            r_sr_fp     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values.
            r_state  <= w_next;
            r_step_q <= step;

            if (w_s1_entry)          r_cnt <= w_s1_last;
            else if (w_s2_entry)     r_cnt <= S2_LAST;
            else if (r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;

            // A halt seen together with start still counts for the first cycle.
            if (r_state == ST_IDLE)     r_halt_seen <= start & halt;
            else if (r_state == ST_GOT) r_halt_seen <= 1'b0;
            else                        r_halt_seen <= r_halt_seen | halt;

            r_strob1  <= (w_next == ST_S1);
            r_strob1b <= (w_next == ST_S1B);
            r_strob2  <= (w_next == ST_S2);
            r_strob2b <= (w_next == ST_S2B);
            r_got     <= (w_next == ST_GOT);
            r_sr_fp   <= (w_next == ST_MREQ);
            r_busy    <= (w_next != ST_IDLE);
        end
    end

    assign strob1  = r_strob1;
    assign strob1b = r_strob1b;
    assign strob2  = r_strob2;
    assign strob2b = r_strob2b;
    assign ldstate = r_got;
    assign got     = r_got;
    assign sr_fp   = r_sr_fp;
    assign busy    = r_busy;

endmodule

// File: tb/tb_awp_strob_seq.sv
// Testbench for awp_strob_seq. Each scenario is a per-cycle plan of inputs plus
// expected outputs. Directed plans are written from the documented timing; the
// random plans are assembled phase by phase from the phase-length rules.
module tb_awp_strob_seq;

    localparam int N      = 256;
    localparam int LEN_S2 = 2;

    // Output vector order: {strob1, strob1b, strob2, strob2b, ldstate, got, sr_fp, busy}
    localparam logic [7:0] PH_IDLE = 8'b0000_0000;
    localparam logic [7:0] PH_S1   = 8'b1000_0001;
    localparam logic [7:0] PH_S1B  = 8'b0100_0001;
    localparam logic [7:0] PH_S2   = 8'b0010_0001;
    localparam logic [7:0] PH_S2B  = 8'b0001_0001;
    localparam logic [7:0] PH_GOT  = 8'b0000_1101;
    localparam logic [7:0] PH_MREQ = 8'b0000_0011;
    localparam logic [7:0] PH_WAIT = 8'b0000_0001;

    logic clk_sys = 1'b0;
    logic rst, start, halt, dp2, dp5, dp6, dp8, f1, zw, oken, di, mode, step;
    logic strob1, strob1b, strob2, strob2b, ldstate, got, sr_fp, busy;
    logic [7:0] w_obs;

    int n_total = 0;
    int n_bad   = 0;

    // Plan storage: one entry per cycle.
    logic [N-1:0] p_rst, p_start, p_halt, p_dp2, p_dp5, p_dp6, p_dp8;
    logic [N-1:0] p_f1, p_zw, p_oken, p_di, p_mode, p_step;
    logic [7:0]   p_exp [N];
    int           p_len;

    awp_strob_seq #(.LEN_S2(LEN_S2)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .start   (start),
        .halt    (halt),
        .dp2     (dp2),
        .dp5     (dp5),
        .dp6     (dp6),
        .dp8     (dp8),
        .f1      (f1),
        .zw      (zw),
        .oken    (oken),
        .di      (di),
        .mode    (mode),
        .step    (step),
        .strob1  (strob1),
        .strob1b (strob1b),
        .strob2  (strob2),
        .strob2b (strob2b),
        .ldstate (ldstate),
        .got     (got),
        .sr_fp   (sr_fp),
        .busy    (busy)
    );

    assign w_obs = {strob1, strob1b, strob2, strob2b, ldstate, got, sr_fp, busy};

    always #5 clk_sys = ~clk_sys;

    task automatic drive_idle();
        rst = 1'b0; start = 1'b0; halt = 1'b0;
        dp2 = 1'b0; dp5 = 1'b0; dp6 = 1'b0; dp8 = 1'b0;
        f1 = 1'b0; zw = 1'b0; oken = 1'b0; di = 1'b0;
        mode = 1'b0; step = 1'b0;
    endtask

    task automatic clear_plan();
        p_rst = '0; p_start = '0; p_halt = '0;
        p_dp2 = '0; p_dp5 = '0; p_dp6 = '0; p_dp8 = '0;
        p_f1 = '0; p_zw = '0; p_oken = '0; p_di = '0;
        p_mode = '0; p_step = '0;
        for (int i = 0; i < N; i++) p_exp[i] = PH_IDLE;
        p_len = 0;
    endtask

    task automatic fill(input int first, input int count, input logic [7:0] ph);
        for (int i = first; i < first + count; i++) p_exp[i] = ph;
    endtask

    // Cycle t: outputs after edge t are compared with p_exp[t], then inputs for t are applied.
    task automatic run_plan(input string name);
        for (int t = 0; t < p_len; t++) begin
            @(posedge clk_sys);
            #1;
            n_total++;
            if (w_obs !== p_exp[t]) begin
                n_bad++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b", name, t, w_obs, p_exp[t]);
            end
            rst = p_rst[t]; start = p_start[t]; halt = p_halt[t];
            dp2 = p_dp2[t]; dp5 = p_dp5[t]; dp6 = p_dp6[t]; dp8 = p_dp8[t];
            f1 = p_f1[t]; zw = p_zw[t]; oken = p_oken[t]; di = p_di[t];
            mode = p_mode[t]; step = p_step[t];
        end
        drive_idle();
    endtask

    // strob1 length from the delay-path lines presented at S1 entry.
    function automatic int s1_len(input int t);
        if (p_dp8[t]) return 8;
        if (p_dp6[t]) return 6;
        if (p_dp5[t]) return 5;
        return 2;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; halt = 1'b0; dp8 = 1'b1; f1 = 1'b1; mode = 1'b1; step = 1'b1;
        @(posedge clk_sys);
        #1;
        n_total++;
        if (w_obs !== PH_IDLE) begin
            n_bad++;
            $display("FAIL reset_outputs: outputs %b, expected %b", w_obs, PH_IDLE);
        end
        drive_idle();
        @(posedge clk_sys);
        #1;
        n_total++;
        if (w_obs !== PH_IDLE) begin
            n_bad++;
            $display("FAIL reset_release: outputs %b, expected %b", w_obs, PH_IDLE);
        end
    endtask

    task automatic test_dp8_single();
        clear_plan();
        p_len = 17;
        p_start[0] = 1'b1; p_dp8[0] = 1'b1; p_halt[5] = 1'b1;
        fill(1, 8, PH_S1);
        p_exp[9] = PH_S1B;
        fill(10, 2, PH_S2);
        p_exp[12] = PH_S2B;
        p_exp[13] = PH_GOT;
        run_plan("dp8_single");
    endtask

    task automatic test_priority();
        clear_plan();
        p_len = 15;
        p_start[0] = 1'b1; p_halt[0] = 1'b1;
        p_dp2[0] = 1'b1; p_dp5[0] = 1'b1; p_dp6[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            p_dp8[k] = 1'b1;
            p_dp2[k] = 1'b1;
        end
        fill(1, 6, PH_S1);
        p_exp[7] = PH_S1B;
        fill(8, 2, PH_S2);
        p_exp[10] = PH_S2B;
        p_exp[11] = PH_GOT;
        run_plan("priority");
    endtask

    task automatic test_mem_read();
        clear_plan();
        p_len = 18;
        p_start[0] = 1'b1; p_f1[3] = 1'b1; p_zw[6] = 1'b1; p_oken[10] = 1'b1; p_halt[14] = 1'b1;
        fill(1, 2, PH_S1);
        p_exp[3] = PH_S1B;
        fill(4, 3, PH_MREQ);
        fill(7, 4, PH_WAIT);
        fill(11, 2, PH_S2);
        p_exp[13] = PH_S2B;
        p_exp[14] = PH_GOT;
        run_plan("mem_read");
    endtask

    task automatic test_abort();
        clear_plan();
        p_len = 11;
        p_start[0] = 1'b1; p_f1[3] = 1'b1; p_zw[4] = 1'b1; p_di[6] = 1'b1; p_halt[7] = 1'b1;
        fill(1, 2, PH_S1);
        p_exp[3] = PH_S1B;
        p_exp[4] = PH_MREQ;
        fill(5, 2, PH_WAIT);
        p_exp[7] = PH_GOT;
        run_plan("abort");
    endtask

    task automatic test_single_step();
        clear_plan();
        p_len = 50;
        p_mode = '1;
        p_start[0] = 1'b1;
        for (int k = 28; k < p_len; k++) p_step[k] = 1'b1;
        p_halt[45] = 1'b1;
        fill(1, 2, PH_S1);
        p_exp[3] = PH_S1B;
        fill(4, 2, PH_S2);
        p_exp[6] = PH_S2B;
        p_exp[7] = PH_GOT;
        fill(8, 21, PH_WAIT);
        fill(29, 2, PH_S1);
        p_exp[31] = PH_S1B;
        fill(32, 2, PH_S2);
        p_exp[34] = PH_S2B;
        p_exp[35] = PH_GOT;
        fill(36, 10, PH_WAIT);
        run_plan("single_step");
    endtask

    task automatic test_reset_mid_s2();
        clear_plan();
        p_len = 20;
        p_start[0] = 1'b1;
        p_rst[4] = 1'b1; p_start[4] = 1'b1;
        p_start[6] = 1'b1; p_dp5[6] = 1'b1; p_halt[16] = 1'b1;
        fill(1, 2, PH_S1);
        p_exp[3] = PH_S1B;
        p_exp[4] = PH_S2;
        fill(7, 5, PH_S1);
        p_exp[12] = PH_S1B;
        fill(13, 2, PH_S2);
        p_exp[15] = PH_S2B;
        p_exp[16] = PH_GOT;
        run_plan("reset_mid_s2");
    endtask

    task automatic test_back_to_back();
        clear_plan();
        p_len = 25;
        p_start[0] = 1'b1; p_dp2[0] = 1'b1; p_halt[21] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fill(1 + 7 * i, 2, PH_S1);
            p_exp[3 + 7 * i] = PH_S1B;
            fill(4 + 7 * i, 2, PH_S2);
            p_exp[6 + 7 * i] = PH_S2B;
            p_exp[7 + 7 * i] = PH_GOT;
        end
        run_plan("back_to_back");
    endtask

    // Build one random job by appending phases of the lengths the rules dictate.
    task automatic build_random();
        int t, s0, entry, n_it, endtype, len, g, zl, ol, ab, w, lo;
        logic mem, aborted;
        clear_plan();
        for (int i = 0; i < N; i++) begin
            p_dp2[i] = 1'($urandom); p_dp5[i] = 1'($urandom);
            p_dp6[i] = 1'($urandom); p_dp8[i] = 1'($urandom);
            p_zw[i] = 1'($urandom); p_oken[i] = 1'($urandom); p_di[i] = 1'($urandom);
            p_mode[i] = 1'($urandom); p_step[i] = 1'($urandom); p_f1[i] = 1'($urandom);
        end
        s0 = int'($urandom_range(3, 1));
        p_start[s0] = 1'b1;
        entry = s0;
        t = s0 + 1;
        n_it = int'($urandom_range(4, 1));
        endtype = int'($urandom_range(2, 0));
        if (endtype == 2) begin
            n_it = 1;
            p_halt[s0] = 1'b1;
        end
        for (int it = 0; it < n_it; it++) begin
            len = s1_len(entry);
            fill(t, len, PH_S1);
            t += len;
            p_exp[t] = PH_S1B;
            mem = p_f1[t];
            t++;
            aborted = 1'b0;
            if (mem) begin
                zl = int'($urandom_range(4, 1));
                ol = int'($urandom_range(4, 1));
                ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(zl + ol, 1)) : 0;
                for (int k = 1; k <= zl + ol && !aborted; k++) begin
                    p_exp[t]  = (k <= zl) ? PH_MREQ : PH_WAIT;
                    p_zw[t]   = (k == zl);
                    p_oken[t] = (k == zl + ol);
                    p_di[t]   = 1'b0;
                    if (k == ab) begin
                        p_di[t] = 1'b1; p_zw[t] = 1'b0; p_oken[t] = 1'b0;
                        aborted = 1'b1;
                    end
                    t++;
                end
            end
            if (!aborted) begin
                fill(t, LEN_S2, PH_S2);
                t += LEN_S2;
                p_exp[t] = PH_S2B;
                t++;
            end
            g = t;
            p_exp[t] = PH_GOT;
            t++;
            if (it != n_it - 1) begin
                if (p_mode[g]) begin
                    p_step[g] = 1'b0;
                    w = int'($urandom_range(4, 0));
                    for (int k = 0; k < w; k++) begin
                        p_exp[t] = PH_WAIT; p_step[t] = 1'b0; t++;
                    end
                    p_exp[t] = PH_WAIT; p_step[t] = 1'b1;
                    entry = t;
                    t++;
                end else begin
                    entry = g;
                end
            end else if (endtype == 0) begin
                lo = (it == 0) ? entry : entry + 1;
                p_halt[$urandom_range(g, lo)] = 1'b1;
            end else if (endtype == 1) begin
                p_mode[g] = 1'b1; p_step[g] = 1'b0;
                w = int'($urandom_range(4, 0));
                for (int k = 0; k < w; k++) begin
                    p_exp[t] = PH_WAIT; p_step[t] = 1'b0; t++;
                end
                p_exp[t] = PH_WAIT; p_step[t] = 1'b0; p_halt[t] = 1'b1;
                t++;
            end
        end
        p_len = t + 3;
        // start pulses while busy must be ignored.
        for (int i = 0; i < p_len; i++)
            if (p_exp[i] != PH_IDLE) p_start[i] = 1'($urandom);
    endtask

    task automatic test_random();
        for (int j = 0; j < 40; j++) begin
            build_random();
            run_plan("random_job");
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        test_reset();
        test_dp8_single();
        test_priority();
        test_mem_read();
        test_abort();
        test_single_step();
        test_reset_mid_s2();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/awp_strob_seq.md
# awp_strob_seq

Strobe sequencer for the AWP (floating-point unit) control path. It sits directly upstream of the F-PS control block and drives that block's state-register updates. It turns a job-start pulse into a repeating cycle of strob1 / strob1b / strob2 / strob2b / got phases. The strob1 phase length is selected each cycle by the delay-path request lines from the current state decode. The sequencer also runs the memory-read handshake toward the CPU interface and supports single-step operation.

## Interface
Parameters:
- LEN_S2, default 2: strob2 phase length in cycles (2..15).

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  one-cycle pulse; begins an AWP job.
- halt  in  1  job end (F-PS `_0_f`); stops the loop at the next GOT.
- dp2, dp5, dp6, dp8  in  1 each  delay-path selects for the current cycle.
- f1  in  1  current cycle is a memory read.
- zw  in  1  interface granted to AWP.
- oken  in  1  memory read completed; data valid.
- di  in  1  interrupt/abort of the memory wait.
- mode  in  1  single-step mode.
- step  in  1  step request, level; rising edge is used.
- strob1, strob1b, strob2, strob2b  out  1 each  phase strobes.
- ldstate  out  1  one-cycle state-register load enable.
- got  out  1  one-cycle end-of-cycle marker, coincident with ldstate.
- sr_fp  out  1  interface access request.
- busy  out  1  sequencer is not in IDLE.

## Operation
States: IDLE, S1, S1B, MREQ, MWAIT, S2, S2B, GOT, STEPW.

- **Reset.** Synchronous reset puts the FSM in IDLE, clears all counters and the step edge register, and drives every output to 0. Reset overrides all other inputs, including in mid-cycle or mid-handshake.
- **IDLE.** `start` moves to S1. `halt` is ignored in IDLE.
- **S1 length.** On entry to S1, latch the length from the dp lines with priority dp8 > dp6 > dp5 > dp2. The lengths are 8, 6, 5 and 2 cycles. If no dp line is active, the length is 2. dp lines are not sampled again until the next S1 entry.
- **S1.** strob1 = 1 for the latched length, then S1B.
- **S1B.** strob1b = 1 for 1 cycle. Next state is MREQ if `f1` = 1, otherwise S2.
- **MREQ.** sr_fp = 1, held until `zw` = 1 is sampled, then MWAIT. sr_fp drops in the cycle after zw is sampled.
- **MWAIT.** Wait for `oken` = 1, then go to S2.
- **Abort.** `di` = 1 in MREQ or MWAIT goes straight to GOT. sr_fp drops, and strob2/strob2b are skipped.
- **S2.** strob2 = 1 for LEN_S2 cycles, then S2B.
- **S2B.** strob2b = 1 for 1 cycle, then GOT.
- **GOT.** ldstate = got = 1 for 1 cycle. Next state:
  - IDLE if `halt` = 1, or if `halt` was sampled at any point since S1 entry (sticky flag, cleared in GOT);
  - else STEPW if `mode` = 1;
  - else S1.
- **STEPW.** Wait for a rising edge of `step` (registered previous value), then go to S1. `halt` in STEPW goes to IDLE.
- **busy** = 1 in every state except IDLE.
- **start outside IDLE** is ignored.
- Exactly one of strob1, strob1b, strob2, strob2b, ldstate is high in any cycle, or none.

## Timing
- start at cycle 0 → strob1 high from cycle 1.
- Non-memory cycle with dp8 active: strob1 cycles 1–8, strob1b cycle 9, strob2 cycles 10–11, strob2b cycle 12, got cycle 13, next strob1 cycle 14.
- Minimum cycle period (dp2, no read): 2 + 1 + LEN_S2 + 1 + 1 = 7 clocks.
- Memory cycle: sr_fp rises the clock after strob1b. Each clock of zw or oken latency extends the cycle by one.
- `halt` and `start` in the same cycle while in IDLE: start wins, and the halt flag is set, so the job runs exactly one cycle.
- The step edge register updates in every state, so a step edge outside STEPW is not remembered.

## Test plan
- **dp8 single cycle.** Reset, start, dp8 = 1, f1 = 0, halt raised at cycle 5 → strob1 8 clocks, got at cycle 13, then IDLE and busy = 0 at cycle 14.
- **Priority.** dp2 = dp5 = dp6 = 1 at S1 entry → strob1 lasts 6 clocks. dp changes during S1 do not alter the length.
- **Memory read.** f1 = 1, zw after 3 clocks, oken 4 clocks later → sr_fp high 3 clocks, strob2 starts the clock after oken, got follows.
- **Abort.** f1 = 1, di pulsed during MWAIT → next cycle is got = ldstate = 1, no strob2 or strob2b, sr_fp already 0.
- **Single step.** mode = 1 → after got the FSM sits in STEPW with no strobes for 20 clocks; a step rising edge gives strob1 the next clock; holding step high gives no further advance.
- **Reset mid-strob2.** rst asserted during S2 → all outputs 0 the next clock, IDLE; a subsequent start runs normally.
